// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for the round-robin arbiter / bus mux.
// Holds sizing constants, the grant index type and the one-hot helper;
// no module state lives here.
package rr_arb_mux_pkg;

  // Largest grant index width the one-hot helper supports.
  localparam int MAX_SEL_WIDTH = 6;
  localparam int MAX_N         = 1 << MAX_SEL_WIDTH;

  // Default configuration of the arbiter (4 requesters, byte data).
  localparam int DEF_SEL_WIDTH = 2;
  localparam int DEF_DAT_WIDTH = 8;

  typedef logic [DEF_SEL_WIDTH-1:0] sel_t;

  // Number of requesters served by a grant index of the given width.
  function automatic int num_req(input int sel_width);
    return 1 << sel_width;
  endfunction

  // Rotate a single set bit left by amt positions; yields one-hot(amt).
  function automatic logic [MAX_N-1:0] rotl_onehot(input int unsigned amt);
    logic [MAX_N-1:0] base;
    base    = '0;
    base[0] = 1'b1;
    return base << (amt % MAX_N);
  endfunction

endpackage

// File: rtl/rr_arb_mux_prio_pick.sv
// Rotating priority encoder: returns the first set bit of vld when scanning
// upward from ptr+1 with wrap-around. Purely combinational, reusable by
// other arbiters.
module rr_prio_pick #(
  parameter int SEL_WIDTH = 2,
  localparam int N = 2**SEL_WIDTH
) (
  input  logic [N-1:0]         vld,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 any
);

  logic [SEL_WIDTH-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest valid one wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |vld;
    for (int i = N; i >= 1; i--) begin
      cand = ptr + SEL_WIDTH'(i);
      if (vld[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter driving a parameterised bus mux between 2**SEL_WIDTH
// valid/ready requesters and a single consumer.
// Build option: define RR_ARB_MUX_OUT_REG_EN to insert a one-entry output
// register after the mux (1-cycle latency, full throughput).
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int SEL_WIDTH = DEF_SEL_WIDTH,
  parameter int DAT_WIDTH = DEF_DAT_WIDTH,
  localparam int N = 2**SEL_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N-1:0]                   req_vld_i,
  output logic [N-1:0]                   req_rdy_o,
  input  logic [N-1:0][DAT_WIDTH-1:0]    req_dat_i,
  output logic                           out_vld_o,
  input  logic                           out_rdy_i,
  output logic [DAT_WIDTH-1:0]           out_dat_o,
  output logic [SEL_WIDTH-1:0]           out_sel_o
);

  logic [SEL_WIDTH-1:0] ptr_q;
  logic [SEL_WIDTH-1:0] gnt_q;
  logic                 lock_q;

  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 pick_any;
  logic [SEL_WIDTH-1:0] grant;
  logic                 mux_vld;
  logic                 arb_rdy;
  logic                 xfer;
  logic [N-1:0]         gnt_oh;
  logic [DAT_WIDTH-1:0] mux_dat;

  rr_prio_pick #(
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .vld (req_vld_i),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // A frozen grant overrides fresh arbitration until its word is taken.
  always_comb begin
    grant   = lock_q ? gnt_q : pick_idx;
    mux_vld = lock_q ? req_vld_i[gnt_q] : pick_any;
    mux_dat = req_dat_i[grant];
    gnt_oh  = N'(rotl_onehot(32'(grant)));
  end

`ifdef RR_ARB_MUX_OUT_REG_EN
  logic                 full_q;
  logic [DAT_WIDTH-1:0] dat_q;
  logic [SEL_WIDTH-1:0] sel_q;

  // The output entry accepts a new word when empty or being drained.
  assign arb_rdy = !full_q | out_rdy_i;
`else
  assign arb_rdy = out_rdy_i;
`endif

  // No handshake completes in a reset cycle.
  assign xfer      = mux_vld & arb_rdy & !rst_i;
  assign req_rdy_o = gnt_oh & {N{xfer}};

`ifdef RR_ARB_MUX_OUT_REG_EN
  // Output entry: refilled in the same cycle it is drained.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      dat_q  <= '0;
      sel_q  <= '0;
    end else if (arb_rdy) begin
      full_q <= mux_vld;
      if (mux_vld) begin
        dat_q <= mux_dat;
        sel_q <= grant;
      end
    end
  end

  assign out_vld_o = full_q;
  assign out_dat_o = dat_q;
  assign out_sel_o = sel_q;
`else
  assign out_vld_o = mux_vld & !rst_i;
  assign out_dat_o = mux_dat;
  assign out_sel_o = grant;
`endif

  // Pointer advances on every transfer; back-pressure freezes the grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '1;
      lock_q <= 1'b0;
      gnt_q  <= '0;
    end else if (xfer) begin
      ptr_q  <= grant;
      lock_q <= 1'b0;
    end
`ifndef RR_ARB_MUX_OUT_REG_EN
    else if (mux_vld) begin
      lock_q <= 1'b1;
      gnt_q  <= grant;
    end
`endif
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed testbench for rr_arb_mux (4 requesters, 8-bit data).
module tb_rr_arb_mux;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      vld;
  logic [3:0]      rdy_w;
  logic [3:0][7:0] dat;
  logic            out_vld;
  logic            out_rdy;
  logic [7:0]      out_dat;
  logic [1:0]      out_sel;

  int checks = 0;
  int errors = 0;

  logic [3:0]      pend = '0;
  logic [3:0][7:0] pend_dat = '0;

  always #5 clk = ~clk;

  rr_arb_mux #(.SEL_WIDTH(2), .DAT_WIDTH(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_vld_i (vld),
    .req_rdy_o (rdy_w),
    .req_dat_i (dat),
    .out_vld_o (out_vld),
    .out_rdy_i (out_rdy),
    .out_dat_o (out_dat),
    .out_sel_o (out_sel)
  );

  // Requester rule: a raised valid holds with stable data until its ready.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          checks++;
          if (!vld[i] || dat[i] !== pend_dat[i]) begin
            errors++;
            $display("FAIL req_rule[%0d] vld=%b dat=%h held=%h", i, vld[i], dat[i], pend_dat[i]);
          end
        end
      end
    end
    pend     <= vld & ~rdy_w & {4{~rst}};
    pend_dat <= dat;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Take every offered word until all requesters have dropped valid.
  task automatic drain();
    logic [3:0] nxt;
    int n = 0;
    out_rdy = 1'b1;
    while (vld != 4'b0000 && n < 20) begin
      @(negedge clk);
      nxt = vld & ~rdy_w;
      tick();
      vld = nxt;
      n++;
    end
    if (vld != 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout vld=%b after %0d cycles", vld, n);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 4'b0000; out_rdy = 1'b1;
    dat = {8'h43, 8'h32, 8'h21, 8'h10};
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_vld_in got %b exp 0", out_vld); end
    checks++; if (rdy_w !== 4'b0000) begin errors++; $display("FAIL rst_rdy_in got %b exp 0000", rdy_w); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", out_vld); end
    checks++; if (rdy_w !== 4'b0000) begin errors++; $display("FAIL rst_rdy got %b exp 0000", rdy_w); end
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", out_sel); end
`ifdef RR_ARB_MUX_OUT_REG_EN
    checks++; if (out_dat !== 8'h00) begin errors++; $display("FAIL rst_dat got %h exp 00", out_dat); end
`else
    checks++; if (out_dat !== 8'h10) begin errors++; $display("FAIL rst_dat got %h exp 10", out_dat); end
`endif
    tick();
  endtask

`ifndef RR_ARB_MUX_OUT_REG_EN
  task automatic test_rotate();
    logic [7:0] exp_dat [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
    vld = 4'b1111; out_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (out_sel !== 2'(k % 4)) begin errors++; $display("FAIL rot_sel[%0d] got %0d exp %0d", k, out_sel, k % 4); end
      checks++; if (rdy_w !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rot_rdy[%0d] got %b exp %b", k, rdy_w, 4'(1 << (k % 4))); end
      checks++; if (out_dat !== exp_dat[k % 4]) begin errors++; $display("FAIL rot_dat[%0d] got %h exp %h", k, out_dat, exp_dat[k % 4]); end
      tick();
    end
    drain();
  endtask

  task automatic test_single();
    dat[2] = 8'hA5; vld = 4'b0100; out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL one_vld[%0d] got %b exp 1", k, out_vld); end
      checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL one_sel[%0d] got %0d exp 2", k, out_sel); end
      checks++; if (out_dat !== 8'hA5) begin errors++; $display("FAIL one_dat[%0d] got %h exp a5", k, out_dat); end
      checks++; if (rdy_w !== 4'b0100) begin errors++; $display("FAIL one_rdy[%0d] got %b exp 0100", k, rdy_w); end
      tick();
    end
    drain();
  endtask

  // Pointer sits at 2 on entry; requester 1 is stalled, then 0 joins.
  task automatic test_backpressure();
    vld = 4'b0010; out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (out_sel !== 2'd1) begin errors++; $display("FAIL bp_sel[%0d] got %0d exp 1", k, out_sel); end
      checks++; if (out_dat !== 8'h21) begin errors++; $display("FAIL bp_dat[%0d] got %h exp 21", k, out_dat); end
      checks++; if (out_vld !== 1'b1 || rdy_w !== 4'b0000) begin errors++; $display("FAIL bp_hs[%0d] got vld=%b rdy=%b exp 1/0000", k, out_vld, rdy_w); end
      tick();
      vld = 4'b0011;
    end
    out_rdy = 1'b1;
    @(negedge clk);
    checks++; if (out_sel !== 2'd1 || rdy_w !== 4'b0010) begin errors++; $display("FAIL bp_release got sel=%0d rdy=%b exp 1/0010", out_sel, rdy_w); end
    tick();
    vld = 4'b0001;
    @(negedge clk);
    checks++; if (out_sel !== 2'd0 || rdy_w !== 4'b0001) begin errors++; $display("FAIL bp_next got sel=%0d rdy=%b exp 0/0001", out_sel, rdy_w); end
    tick();
    vld = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    out_rdy = 1'b1;
    vld = 4'b1000;
    @(negedge clk);
    checks++; if (out_sel !== 2'd3) begin errors++; $display("FAIL wrap_pre got %0d exp 3", out_sel); end
    tick();
    for (int r = 0; r < 2; r++) begin
      vld = 4'b1001;
      @(negedge clk);
      checks++; if (out_sel !== 2'd0 || rdy_w !== 4'b0001) begin errors++; $display("FAIL wrap_0[%0d] got sel=%0d rdy=%b exp 0/0001", r, out_sel, rdy_w); end
      tick();
      vld = 4'b1000;
      @(negedge clk);
      checks++; if (out_sel !== 2'd3 || rdy_w !== 4'b1000) begin errors++; $display("FAIL wrap_3[%0d] got sel=%0d rdy=%b exp 3/1000", r, out_sel, rdy_w); end
      tick();
      vld = 4'b0000;
      @(negedge clk);
      checks++; if (out_vld !== 1'b0 || rdy_w !== 4'b0000) begin errors++; $display("FAIL idle[%0d] got vld=%b rdy=%b exp 0/0000", r, out_vld, rdy_w); end
      tick();
    end
  endtask

  task automatic test_reset_locked();
    vld = 4'b0100; out_rdy = 1'b0;
    @(negedge clk);
    checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL rl_lock got %0d exp 2", out_sel); end
    tick();
    rst = 1'b1; vld = 4'b1111; out_rdy = 1'b1;
    @(negedge clk);
    checks++; if (rdy_w !== 4'b0000 || out_vld !== 1'b0) begin errors++; $display("FAIL rl_rst got rdy=%b vld=%b exp 0000/0", rdy_w, out_vld); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_sel !== 2'd0 || rdy_w !== 4'b0001) begin errors++; $display("FAIL rl_first got sel=%0d rdy=%b exp 0/0001", out_sel, rdy_w); end
    tick();
    @(negedge clk);
    checks++; if (out_sel !== 2'd1) begin errors++; $display("FAIL rl_second got %0d exp 1", out_sel); end
    tick();
    drain();
  endtask
`else
  task automatic test_reg_rotate();
    logic [7:0] exp_dat [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
    vld = 4'b1111; out_rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reg_lat got %b exp 0", out_vld); end
      end else begin
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL reg_bubble[%0d] got %b exp 1", k, out_vld); end
        checks++; if (out_sel !== 2'((k - 1) % 4)) begin errors++; $display("FAIL reg_sel[%0d] got %0d exp %0d", k, out_sel, (k - 1) % 4); end
        checks++; if (out_dat !== exp_dat[(k - 1) % 4]) begin errors++; $display("FAIL reg_dat[%0d] got %h exp %h", k, out_dat, exp_dat[(k - 1) % 4]); end
      end
      if (k < 8) begin
        checks++; if (rdy_w !== 4'(1 << (k % 4))) begin errors++; $display("FAIL reg_rdy[%0d] got %b exp %b", k, rdy_w, 4'(1 << (k % 4))); end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reg_toggle();
    logic [9:0] q [$];
    logic [9:0] exp;
    logic [3:0] adv;
    int pushed = 0;
    int popped = 0;
    dat = {8'hC0, 8'h80, 8'h40, 8'h00};
    vld = 4'b1111; out_rdy = 1'b1;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (out_vld && out_rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL reg_dup got sel=%0d dat=%h exp none", out_sel, out_dat);
        end else begin
          exp = q.pop_front(); popped++;
          if ({out_sel, out_dat} !== exp) begin errors++; $display("FAIL reg_word got %h exp %h", {out_sel, out_dat}, exp); end
        end
      end
      adv = rdy_w;
      for (int i = 0; i < 4; i++) if (adv[i]) begin q.push_back({2'(i), dat[i]}); pushed++; end
      tick();
      for (int i = 0; i < 4; i++) if (adv[i]) dat[i] = dat[i] + 8'h01;
      if (c < 16) out_rdy = ~out_rdy;
      else begin vld = vld & ~adv; out_rdy = 1'b1; end
    end
    checks++; if (q.size() != 0 || pushed != popped) begin errors++; $display("FAIL reg_lost got popped=%0d exp %0d", popped, pushed); end
    checks++; if (pushed < 8) begin errors++; $display("FAIL reg_rate got %0d words exp >= 8", pushed); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef RR_ARB_MUX_OUT_REG_EN
    test_reg_rotate();
    test_reg_toggle();
`else
    test_rotate();
    test_single();
    test_backpressure();
    test_wrap();
    test_reset_locked();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
